// File: rtl/sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package sram_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   localparam int SRAM_HW = 16;
   localparam int SRAM_AW = 23;

   // Number of half-word beats needed to move one channel word.
   function automatic int beats_of(input int dw);
      return dw / SRAM_HW;
   endfunction

endpackage

// File: rtl/sram_arb.sv
// Channel arbiter: fixed priority (lowest index wins), or round-robin when
// SRAM_RR_ARB_EN is defined.
module sram_arb
   import sram_pkg::*;
#(
   parameter int N_CH = 3,
   parameter int IW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
`ifdef SRAM_RR_ARB_EN
   input  logic            clk,
   input  logic            rst,
   input  logic            advance,
`endif
   input  logic [N_CH-1:0] req,
   output logic [N_CH-1:0] grant,
   output logic [IW-1:0]   idx
);

`ifdef SRAM_RR_ARB_EN
   logic [IW-1:0] ptr;

   // Search starts just after the last winner, wrapping at N_CH.
   always_comb begin
      int j;
      grant = '0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < N_CH; k++) begin
         j = int'(ptr) + k;
         if (j >= N_CH) j = j - N_CH;
         if (grant == '0 && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (advance)
         ptr <= (int'(idx) == N_CH - 1) ? '0 : idx + 1'b1;
   end
`else
   always_comb begin
      grant = '0;
      idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            idx      = IW'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/sram_arbiter_ctrl.sv
// Multi-channel controller for a 16-bit asynchronous SRAM; channel words are
// split into upper-half-first beats. SRAM_RR_ARB_EN selects round-robin arbitration.
module sram_arbiter_ctrl
   import sram_pkg::*;
#(
   parameter int N_CH     = 3,
   parameter int DW       = 32,
   parameter int WAIT_CYC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       ch_req,
   input  logic [N_CH-1:0]       ch_we,
   input  logic [N_CH*24-1:0]    ch_addr,
   input  logic [N_CH*DW-1:0]    ch_wdata,
   input  logic [N_CH*DW/8-1:0]  ch_be,
   output logic [N_CH-1:0]       ch_ack,
   output logic [DW-1:0]         rdata,
   output logic                  busy,
   output logic [SRAM_AW-1:0]    sram_addr,
   inout  wire  [SRAM_HW-1:0]    sram_data,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_lb_n,
   output logic                  sram_ub_n,
   output logic                  sram_clk,
   output logic                  sram_adv,
   output logic                  sram_cre
);

   localparam int BEATS = beats_of(DW);
   localparam int BEW   = DW / 8;
   localparam int IW    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int CW    = 4;

   state_t            state;
   logic [CW-1:0]     cnt;
   logic              beat;
   logic [N_CH-1:0]   grant_oh;
   logic              lat_we;
   logic [23:0]       lat_addr;
   logic [DW-1:0]     lat_wdata;
   logic [BEW-1:0]    lat_be;
   logic [DW-1:0]     rd_buf;
   logic [DW-1:0]     rd_merge;
   logic              data_oe;
   logic [SRAM_HW-1:0] data_out;

   logic [N_CH-1:0]   arb_grant;
   logic [IW-1:0]     arb_idx;
   logic              sel_we;
   logic [23:0]       sel_addr;
   logic [DW-1:0]     sel_wdata;
   logic [BEW-1:0]    sel_be;

`ifdef SRAM_RR_ARB_EN
   logic advance;
   assign advance = (state == IDLE) && (ch_req != '0);
`endif

   sram_arb #(.N_CH(N_CH), .IW(IW)) u_arb (
`ifdef SRAM_RR_ARB_EN
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
`endif
      .req     (ch_req),
      .grant   (arb_grant),
      .idx     (arb_idx)
   );

   assign sel_we    = ch_we[arb_idx];
   assign sel_addr  = ch_addr[int'(arb_idx)*24 +: 24];
   assign sel_wdata = ch_wdata[int'(arb_idx)*DW +: DW];
   assign sel_be    = ch_be[int'(arb_idx)*BEW +: BEW];

   assign sram_data = data_oe ? data_out : 'z;
   assign sram_clk  = 1'b0;
   assign sram_adv  = 1'b0;
   assign sram_cre  = 1'b0;

   function automatic logic [SRAM_HW-1:0] half_of(input logic [DW-1:0] d, input logic b);
      return d[DW-1-SRAM_HW*int'(b) -: SRAM_HW];
   endfunction

   // Returns {ub, lb} enables of the given beat's half-word.
   function automatic logic [1:0] be_of(input logic [BEW-1:0] be, input logic b);
      return be[BEW-1-2*int'(b) -: 2];
   endfunction

   function automatic logic [SRAM_AW-1:0] beat_addr(input logic [23:0] a, input logic b);
      if (DW == 32) return {a[23:2], b};
      else          return a[23:1];
   endfunction

   // we_n is held off on the first and last cycle of a beat for setup/hold.
   function automatic logic we_active(input logic we, input logic [1:0] be2, input logic [CW-1:0] ncnt);
      return we && (be2 != 2'b00) && (ncnt != '0) && (int'(ncnt) <= WAIT_CYC - 2);
   endfunction

   always_comb begin
      rd_merge = rd_buf;
      rd_merge[DW-1-SRAM_HW*int'(beat) -: SRAM_HW] = sram_data;
   end

   // Single FSM; every SRAM pin is registered so the async strobes are glitch-free.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         beat      <= 1'b0;
         grant_oh  <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
         rd_buf    <= '0;
         rdata     <= '0;
         ch_ack    <= '0;
         busy      <= 1'b0;
         sram_addr <= '0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
         sram_lb_n <= 1'b1;
         sram_ub_n <= 1'b1;
         data_oe   <= 1'b0;
         data_out  <= '0;
      end else begin
         case (state)
            IDLE: begin
               ch_ack <= '0;
               if (ch_req != '0) begin
                  state     <= ACCESS;
                  cnt       <= '0;
                  beat      <= 1'b0;
                  grant_oh  <= arb_grant;
                  lat_we    <= sel_we;
                  lat_addr  <= sel_addr;
                  lat_wdata <= sel_wdata;
                  lat_be    <= sel_be;
                  busy      <= 1'b1;
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= sel_we;
                  sram_we_n <= 1'b1;
                  {sram_ub_n, sram_lb_n} <= sel_we ? ~be_of(sel_be, 1'b0) : 2'b00;
                  sram_addr <= beat_addr(sel_addr, 1'b0);
                  data_oe   <= sel_we;
                  data_out  <= half_of(sel_wdata, 1'b0);
               end
            end
            ACCESS: begin
               if (cnt == CW'(WAIT_CYC - 1)) begin
                  if (!lat_we) rd_buf <= rd_merge;
                  if (beat == 1'(BEATS - 1)) begin
                     state     <= DONE;
                     ch_ack    <= grant_oh;
                     if (!lat_we) rdata <= rd_merge;
                     sram_ce_n <= 1'b1;
                     sram_oe_n <= 1'b1;
                     sram_we_n <= 1'b1;
                     sram_lb_n <= 1'b1;
                     sram_ub_n <= 1'b1;
                     data_oe   <= 1'b0;
                  end else begin
                     cnt       <= '0;
                     beat      <= ~beat;
                     sram_we_n <= 1'b1;
                     {sram_ub_n, sram_lb_n} <= lat_we ? ~be_of(lat_be, ~beat) : 2'b00;
                     sram_addr <= beat_addr(lat_addr, ~beat);
                     data_out  <= half_of(lat_wdata, ~beat);
                  end
               end else begin
                  cnt       <= cnt + 1'b1;
                  sram_we_n <= ~we_active(lat_we, be_of(lat_be, beat), cnt + 1'b1);
               end
            end
            DONE: begin
               ch_ack <= '0;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
